regfile_wport_arbiter: RTL and testbench
========================================

// Module: regfile_wport_arbiter
// PURPOSE
//  Shares the single register-file write port between the in-order WB stage and a long-latency
//  writer (mul/div unit, cache-miss load return). Long-latency results queue in a small FIFO and
//  drain in cycles the WB stage leaves idle. A pending-destination scoreboard feeds hazard detection.
//  Sits between the pipeline back end and the register file, which writes on the negedge.
// PARAMETERS
//  DATA_W      32  write data width
//  ADDR_W      5   register address width; number of pending bits = 2**ADDR_W
//  FIFO_DEPTH  4   long-latency queue entries (power of 2, >=2)
// PORTS
//  clock      in   1        posedge; all state updates on rising edge
//  reset      in   1        reset, asynchronous, active-high
//  wb_valid   in   1        WB stage has a write this cycle
//  wb_addr    in   ADDR_W   WB destination
//  wb_data    in   DATA_W   WB data
//  wb_stall   out  1        comb: WB write not taken, hold WB stage
//  ll_valid   in   1        long-latency result offered
//  ll_ready   out  1        comb: FIFO not full; transfer = ll_valid & ll_ready
//  ll_addr    in   ADDR_W   long-latency destination
//  ll_data    in   DATA_W   long-latency data
//  iss_valid  in   1        long-latency op issued; marks iss_addr pending
//  iss_addr   in   ADDR_W   issued destination
//  pending    out  2**ADDR_W  registered scoreboard, bit n = reg n awaits a long-latency write
//  rf_we      out  1        registered write enable to register file
//  rf_waddr   out  ADDR_W   registered write address
//  rf_wdata   out  DATA_W   registered write data
//  fifo_cnt   out  clog2(FIFO_DEPTH)+1  registered occupancy
// BEHAVIOUR
//  - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, fifo_cnt=0, pointers=0; queued entries lost.
//    Reset mid-operation discards queued writes; no partial write reaches rf.
//  - Grant per cycle (comb): full = (fifo_cnt==FIFO_DEPTH).
//    * !full & wb_valid          -> WB granted, wb_stall=0.
//    * full                      -> FIFO head granted; wb_stall=wb_valid.
//    * !wb_valid & fifo_cnt!=0   -> FIFO head granted (pop).
//    * otherwise                 -> idle.
//  - Latency: granted write appears on rf_* at the next rising edge (1 cycle); rf commits on the
//    following negedge. rf_we=0 in idle cycles; rf_waddr/rf_wdata hold last value.
//  - Address 0: granted write with addr 0 drives rf_we=0 but is still consumed (popped / acked).
//  - FIFO: push when ll_valid & ll_ready; push and pop in same cycle allowed, fifo_cnt unchanged.
//    ll_ready = !full, so push while full is impossible even if pop occurs that cycle.
//    Pointers wrap modulo FIFO_DEPTH. Order strictly FIFO.
//  - Scoreboard: bit set on iss_valid (iss_addr!=0); cleared when a FIFO entry for that addr is
//    granted (edge same as rf_we registration). Same-cycle set and clear of same addr: set wins.
//    WB grants never touch pending. Bit 0 always 0.
//  - fifo_cnt never exceeds FIFO_DEPTH; underflow impossible (pop only if cnt!=0).
// CONFIGURATION
//  RFARB_FWD_EN defined: adds ports fwd_addr (in, ADDR_W), fwd_hit (out,1), fwd_data (out,DATA_W);
//   comb search of valid FIFO entries, youngest match wins; fwd_addr==0 -> fwd_hit=0, fwd_data=0.
//   Entry granted this cycle still searchable. No match -> fwd_hit=0, fwd_data=0.
//  Not defined: ports and search logic absent; all other behaviour identical.
// STRUCTURE
//  Package regfile_arb_pkg: DATA_W/ADDR_W defaults, typedef rf_wr_t {addr, data}, grant-source
//   enum {GNT_IDLE, GNT_WB, GNT_LL}.
//  Sub-module rf_wr_fifo: synchronous FIFO of rf_wr_t with count, push/pop, and (under
//   RFARB_FWD_EN) entry visibility for the forward search. Arbiter + scoreboard in top.
// TESTING
//  1 WB only: wb_valid=1, addr=8, data=0x1234 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234.
//  2 Collision: wb(addr3,0xA) and ll(addr5,0xB) same cycle -> rf gets 3/0xA, fifo_cnt=1;
//    next idle WB cycle rf gets 5/0xB, fifo_cnt=0.
//  3 Full: push 4 ll entries with wb_valid held 1 -> wb_stall=1, FIFO head drains,
//    ll_ready=0 until cnt<4; WB write completes after stall drops.
//  4 Scoreboard: iss addr 9 -> pending[9]=1; ll write to 9 granted -> pending[9]=0;
//    iss 9 same cycle as grant of 9 -> pending[9] stays 1.
//  5 Addr 0: ll(addr0,0xFF) -> popped, rf_we stays 0, pending[0]=0.
//  6 Reset mid-drain with fifo_cnt=3 -> all outputs 0, no rf_we after release.
//    RFARB_FWD_EN: queue 7/0x1 then 7/0x2, fwd_addr=7 -> fwd_hit=1, fwd_data=0x2.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, write-record type and grant-source encoding for the write-port arbiter
package regfile_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;
  typedef enum logic [1:0] {GNT_IDLE, GNT_WB, GNT_LL} gnt_e;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: synchronous FIFO of write records; RFARB_FWD_EN exposes entries oldest-first for forward search
module rf_wr_fifo
  import regfile_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = rf_wr_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
`ifdef RFARB_FWD_EN
  output T [DEPTH-1:0] ord,
  output logic [DEPTH-1:0] vld,
`endif
  output logic [CW-1:0] cnt
);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  // pointers wrap naturally at DEPTH; count tracks push/pop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  // storage needs no reset: count gates which entries are meaningful
  always_ff @(posedge clock)
    if (push) mem[wp] <= din;
  assign dout = mem[rp];
`ifdef RFARB_FWD_EN
  // entries in age order, index 0 = head
  always_comb
    for (int i = 0; i < DEPTH; i++) begin
      ord[i] = mem[rp + AW'(i)];
      vld[i] = CW'(i) < cnt;
    end
`endif
endmodule

// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the RF write port between WB and a queued long-latency writer, with pending scoreboard (optional RFARB_FWD_EN forward search)
module regfile_wport_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = regfile_arb_pkg::DATA_W,
  parameter int ADDR_W = regfile_arb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clock,
  input  logic reset,
  input  logic wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic wb_stall,
  input  logic ll_valid,
  output logic ll_ready,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic [DATA_W-1:0] ll_data,
  input  logic iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [2**ADDR_W-1:0] pending,
  output logic rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef RFARB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [CW-1:0] fifo_cnt
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;
  wr_t head, w;
  gnt_e gnt;
  logic full, push, we_nxt;
  logic [2**ADDR_W-1:0] pend_nxt;
`ifdef RFARB_FWD_EN
  wr_t [FIFO_DEPTH-1:0] ord;
  logic [FIFO_DEPTH-1:0] vld;
`endif
  rf_wr_fifo #(.DEPTH(FIFO_DEPTH), .T(wr_t)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(push),
    .pop(gnt == GNT_LL),
    .din({ll_addr, ll_data}),
    .dout(head),
`ifdef RFARB_FWD_EN
    .ord(ord),
    .vld(vld),
`endif
    .cnt(fifo_cnt)
  );
  // grant: WB first unless the queue is full, otherwise drain the head when any is queued
  always_comb begin
    full = fifo_cnt == CW'(FIFO_DEPTH);
    gnt = (!full && wb_valid) ? GNT_WB : (fifo_cnt != '0) ? GNT_LL : GNT_IDLE;
    w = (gnt == GNT_WB) ? wr_t'({wb_addr, wb_data}) : head;
    we_nxt = gnt != GNT_IDLE && w.addr != '0;
    wb_stall = wb_valid && full;
    ll_ready = !full;
    push = ll_valid && !full;
  end
  // scoreboard: clear on queued-write grant, then set on issue so a same-cycle set wins
  always_comb begin
    pend_nxt = pending;
    if (gnt == GNT_LL) pend_nxt[head.addr] = 1'b0;
    if (iss_valid) pend_nxt[iss_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end
  // register the granted write; address 0 is consumed without enabling the RF
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending <= '0;
    end else begin
      rf_we <= we_nxt;
      if (we_nxt) begin
        rf_waddr <= w.addr;
        rf_wdata <= w.data;
      end
      pending <= pend_nxt;
    end
`ifdef RFARB_FWD_EN
  // youngest matching queued entry wins; address 0 never hits
  always_comb begin
    fwd_hit = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (vld[i] && ord[i].addr == fwd_addr && fwd_addr != '0) begin
        fwd_hit = 1'b1;
        fwd_data = ord[i].data;
      end
  end
`endif
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed plus random checking against a queue-based model of the write-port arbiter
module tb_regfile_wport_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic wb_valid, ll_valid, iss_valid;
  logic [4:0] wb_addr, ll_addr, iss_addr;
  logic [31:0] wb_data, ll_data;
  logic wb_stall, ll_ready, rf_we;
  logic [31:0] pending;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0] fifo_cnt;
`ifdef RFARB_FWD_EN
  logic [4:0] fwd_addr;
  logic fwd_hit;
  logic [31:0] fwd_data;
`endif
  int vecs = 0;
  int bad = 0;
  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];
  logic [31:0] m_pend;
  logic m_we;
  logic [4:0] m_waddr;
  logic [31:0] m_wdata;

  always #5 clock = ~clock;

  regfile_wport_arbiter dut (
    .clock(clock),
    .reset(reset),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .wb_stall(wb_stall),
    .ll_valid(ll_valid),
    .ll_ready(ll_ready),
    .ll_addr(ll_addr),
    .ll_data(ll_data),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .pending(pending),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
`ifdef RFARB_FWD_EN
    .fwd_addr(fwd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
`endif
    .fifo_cnt(fifo_cnt)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = '0;
    m_we = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // one cycle: drive, check comb outputs, advance model, check registered outputs after the edge
  task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ia);
    bit full, g, h;
    ent_t e;
    logic [31:0] fd;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    ll_valid = lv; ll_addr = la; ll_data = ld;
    iss_valid = iv; iss_addr = ia;
    #1;
    full = q.size() == 4;
    chk("wb_stall", wb_stall, wv && full);
    chk("ll_ready", ll_ready, !full);
`ifdef RFARB_FWD_EN
    h = 0;
    fd = 0;
    foreach (q[i]) if (fwd_addr != 0 && q[i].a == fwd_addr) begin h = 1; fd = q[i].d; end
    chk("fwd_hit", fwd_hit, h);
    chk("fwd_data", fwd_data, fd);
`else
    h = 0;
    fd = 0;
`endif
    g = 0;
    e = '{0, 0};
    if (wv && !full) begin
      e = '{wa, wd};
      g = 1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      g = 1;
      m_pend[e.a] = 1'b0;
    end
    if (lv && !full) q.push_back('{la, ld});
    if (iv && ia != 0) m_pend[ia] = 1'b1;
    m_pend[0] = 1'b0;
    m_we = g && e.a != 0;
    if (m_we) begin
      m_waddr = e.a;
      m_wdata = e.d;
    end
    @(posedge clock);
    #1;
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("pending", pending, m_pend);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0;
    iss_valid = 0; iss_addr = 0;
`ifdef RFARB_FWD_EN
    fwd_addr = 0;
`endif
    model_reset();
    #12;
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_waddr", rf_waddr, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset pending", pending, 0);
    chk("reset fifo_cnt", fifo_cnt, 0);
    reset = 1'b0;

    step(1, 8, 'h1234, 0, 0, 0, 0, 0);
    chk("t1 rf_we", rf_we, 1);
    chk("t1 rf_waddr", rf_waddr, 8);
    chk("t1 rf_wdata", rf_wdata, 'h1234);

    step(1, 3, 'hA, 1, 5, 'hB, 0, 0);
    chk("t2 rf_waddr", rf_waddr, 3);
    chk("t2 rf_wdata", rf_wdata, 'hA);
    chk("t2 fifo_cnt", fifo_cnt, 1);
    idle();
    chk("t2 drain rf_waddr", rf_waddr, 5);
    chk("t2 drain rf_wdata", rf_wdata, 'hB);
    chk("t2 drain fifo_cnt", fifo_cnt, 0);

    for (int i = 0; i < 4; i++) step(1, 5'(10 + i), i, 1, 5'(20 + i), 100 + i, 0, 0);
    chk("t3 fifo_cnt full", fifo_cnt, 4);
    wb_valid = 1;
    #1;
    chk("t3 wb_stall", wb_stall, 1);
    chk("t3 ll_ready", ll_ready, 0);
    step(1, 1, 'h77, 1, 30, 'h9, 0, 0);
    chk("t3 head rf_waddr", rf_waddr, 20);
    chk("t3 head rf_wdata", rf_wdata, 100);
    chk("t3 fifo_cnt", fifo_cnt, 3);
    step(1, 1, 'h77, 0, 0, 0, 0, 0);
    chk("t3 wb rf_waddr", rf_waddr, 1);
    chk("t3 wb rf_wdata", rf_wdata, 'h77);
    repeat (3) idle();

    step(0, 0, 0, 0, 0, 0, 1, 9);
    chk("t4 set", pending[9], 1);
    step(1, 2, 2, 1, 9, 'h99, 0, 0);
    idle();
    chk("t4 clear", pending[9], 0);
    step(1, 2, 2, 1, 9, 'h98, 1, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9);
    chk("t4 set wins", pending[9], 1);
    chk("t4 rf_waddr", rf_waddr, 9);

    step(1, 4, 4, 1, 0, 'hFF, 0, 0);
    idle();
    chk("t5 rf_we", rf_we, 0);
    chk("t5 fifo_cnt", fifo_cnt, 0);
    chk("t5 pending0", pending[0], 0);

`ifdef RFARB_FWD_EN
    step(1, 2, 1, 1, 7, 'h1, 0, 0);
    step(1, 2, 1, 1, 7, 'h2, 0, 0);
    fwd_addr = 7;
    #1;
    chk("fwd youngest hit", fwd_hit, 1);
    chk("fwd youngest data", fwd_data, 'h2);
    idle();
    idle();
    fwd_addr = 0;
`endif

    for (int i = 0; i < 4; i++) step(1, 5'(11 + i), i, 1, 5'(12 + i), 'h50 + i, 1, 5'(12 + i));
    idle();
    chk("t6 fifo_cnt", fifo_cnt, 3);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6 rf_we", rf_we, 0);
    chk("t6 rf_waddr", rf_waddr, 0);
    chk("t6 rf_wdata", rf_wdata, 0);
    chk("t6 pending", pending, 0);
    chk("t6 fifo_cnt", fifo_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    idle();
    chk("t6 no write", rf_we, 0);

    repeat (3000) begin
`ifdef RFARB_FWD_EN
      fwd_addr = 5'($urandom_range(0, 7));
`endif
      step($urandom_range(0, 9) < 6, 5'($urandom), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end
endmodule
